// File: rtl/wb_bisect_responder.sv
`timescale 1ns/1ps
// Wishbone classic register front-end for an iterative integer bisection square-root finder.
// Latency: ack one cycle after a hit; start acked at T -> CHECK T+1 -> done/irq at T+3+iterations.
// Backpressure: none; exactly one ack per strobe, a held strobe is not acked twice.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i  Wishbone classic control
//   wbs_sel_i             byte enables (lanes 0/1 carry register data)
//   wbs_adr_i, wbs_dat_i  byte address and write data
//   wbs_ack_o, wbs_dat_o  registered one-cycle ack and read data (0 when ack low)
//   irq_o                 one-cycle pulse when a computation reaches DONE
// The byte-lane register layout (lo at [7:0], hi at [15:8], N at [15:0]) assumes WIDTH = 8.
module wb_bisect_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          WIDTH     = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);
    localparam int NW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_t;

    // bus side
    logic        hit;
    logic        take;
    logic        ack_q;
    logic        served_q;
    logic [31:0] dat_q;
    logic [31:0] rd_mux;
    logic [1:0]  reg_sel;
    logic        bus_wr;
    logic        start_cmd;

    // host-visible operand registers
    logic [WIDTH-1:0] oper_lo;
    logic [WIDTH-1:0] oper_hi;
    logic [NW-1:0]    tgt_n;

    // solver state (private copies so host writes never disturb a running search)
    state_t           state;
    logic [WIDTH-1:0] c_lo;
    logic [WIDTH-1:0] c_hi;
    logic [NW-1:0]    c_n;
    logic [WIDTH-1:0] root_q;
    logic [3:0]       iter_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             irq_q;

    // datapath helpers
    logic [NW-1:0]    lo_sq;
    logic [NW-1:0]    hi_sq;
    logic [NW-1:0]    mid_sq;
    logic [WIDTH:0]   mid_sum;
    logic [WIDTH-1:0] mid;
    logic [WIDTH-1:0] span;
    logic             bad_bracket;

    logic unused_bits;

    assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // served_q remembers that the current strobe was already acked, so a master
    // that keeps stb high past the ack never sees a second ack.
    assign take      = hit & ~ack_q & ~served_q;
    assign reg_sel   = wbs_adr_i[3:2];
    // Writes land at the end of the ack cycle; the classic master still holds data then.
    assign bus_wr    = ack_q & hit & wbs_we_i;
    assign start_cmd = bus_wr & (reg_sel == 2'd2) & wbs_sel_i[0] & wbs_dat_i[0];

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            2'd0: begin
                rd_mux[WIDTH-1:0] = oper_lo;
                rd_mux[8 +: WIDTH] = oper_hi;
            end
            2'd1:    rd_mux[NW-1:0] = tgt_n;
            2'd2:    rd_mux[2:0] = {err_q, done_q, busy_q};
            default: begin
                rd_mux[WIDTH-1:0] = root_q;
                rd_mux[11:8]      = iter_q;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack_q    <= 1'b0;
            served_q <= 1'b0;
            dat_q    <= '0;
        end else begin
            ack_q    <= take;
            served_q <= hit & (served_q | ack_q);
            dat_q    <= (take & ~wbs_we_i) ? rd_mux : '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oper_lo <= '0;
            oper_hi <= '0;
            tgt_n   <= '0;
        end else if (bus_wr) begin
            if (reg_sel == 2'd0) begin
                if (wbs_sel_i[0]) oper_lo <= wbs_dat_i[WIDTH-1:0];
                if (wbs_sel_i[1]) oper_hi <= wbs_dat_i[8 +: WIDTH];
            end else if (reg_sel == 2'd1) begin
                if (wbs_sel_i[0]) tgt_n[7:0]    <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) tgt_n[NW-1:8] <= wbs_dat_i[NW-1:8];
            end
        end
    end

    always_comb begin
        lo_sq       = NW'(c_lo) * NW'(c_lo);
        hi_sq       = NW'(c_hi) * NW'(c_hi);
        // one extra bit keeps lo+hi from wrapping near the top of the range
        mid_sum     = {1'b0, c_lo} + {1'b0, c_hi};
        mid         = mid_sum[WIDTH:1];
        mid_sq      = NW'(mid) * NW'(mid);
        span        = c_hi - c_lo;
        bad_bracket = (c_lo > c_hi) || (lo_sq > c_n) || (hi_sq <= c_n);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            c_lo   <= '0;
            c_hi   <= '0;
            c_n    <= '0;
            root_q <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_cmd) begin
                        c_lo   <= oper_lo;
                        c_hi   <= oper_hi;
                        c_n    <= tgt_n;
                        root_q <= '0;
                        iter_q <= '0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    // the invariant lo*lo <= N < hi*hi must hold before bisecting
                    if (bad_bracket) begin
                        err_q  <= 1'b1;
                        root_q <= '0;
                        iter_q <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        irq_q  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    if (span <= WIDTH'(1)) begin
                        root_q <= c_lo;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        irq_q  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        if (mid_sq <= c_n) c_lo <= mid;
                        else               c_hi <= mid;
                        if (iter_q != 4'hF) iter_q <= iter_q + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;

    assign unused_bits = ^{wbs_dat_i[31:16], wbs_sel_i[3:2], wbs_adr_i[1:0], mid_sum[0]};
endmodule

// File: tb/tb_wb_bisect_responder.sv
`timescale 1ns/1ps
module tb_wb_bisect_responder;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, dat_i = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic        irq;

    wb_bisect_responder #(.BASE_ADDR(BASE), .WIDTH(8)) dut (
        .clock(clock), .reset(reset),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o), .irq_o(irq)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0, cyc_n = 0, irq_cnt = 0;
    always @(posedge clock) cyc_n <= cyc_n + 1;
    always @(negedge clock) if (irq === 1'b1) irq_cnt++;

    // ---------------- behavioural model ----------------
    logic [7:0]  m_lo = 0, m_hi = 0;
    logic [15:0] m_n = 0;
    bit          run_valid = 0, run_err = 0;
    int          run_t = 0, run_done = 0;
    logic [7:0]  run_root = 0;
    logic [3:0]  run_iter = 0;
    int          exp_ack_cycle = -10;
    logic [31:0] exp_dat = 0;
    bit          exp_known = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    function automatic int isqrt(input int n);
        int r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    function automatic int bisect_steps(input int lo, input int hi, input int n);
        int l = lo, h = hi, k = 0, m;
        while (h - l > 1) begin
            m = (l + h) / 2;
            if (m * m <= n) l = m; else h = m;
            k++;
        end
        return k;
    endfunction

    function automatic bit model_busy(input int x);
        return run_valid && x > run_t && x < run_done;
    endfunction

    task automatic model_start(input int t);
        int lo, hi, n, k;
        if (model_busy(t)) return;
        lo = m_lo; hi = m_hi; n = m_n;
        run_valid = 1; run_t = t;
        if (lo > hi || lo * lo > n || hi * hi <= n) begin
            run_err = 1; run_root = 0; run_iter = 0; run_done = t + 2;
        end else begin
            k = bisect_steps(lo, hi, n);
            run_err = 0; run_root = 8'(isqrt(n));
            run_iter = (k > 15) ? 4'hF : 4'(k);
            run_done = t + 3 + k;
        end
    endtask

    task automatic model_write(input logic [1:0] r, input logic [3:0] s, input logic [31:0] d, input int t);
        case (r)
            2'd0: begin if (s[0]) m_lo = d[7:0]; if (s[1]) m_hi = d[15:8]; end
            2'd1: begin if (s[0]) m_n[7:0] = d[7:0]; if (s[1]) m_n[15:8] = d[15:8]; end
            2'd2: if (s[0] && d[0]) model_start(t);
            default: ;
        endcase
    endtask

    task automatic model_read(input logic [1:0] r, input int x, output logic [31:0] d, output bit known);
        bit dn;
        dn = run_valid && x >= run_done;
        known = 1;
        case (r)
            2'd0: d = {16'h0, m_hi, m_lo};
            2'd1: d = {16'h0, m_n};
            2'd2: d = {29'h0, dn && run_err, dn, model_busy(x)};
            default: begin
                if (!run_valid) d = 0;
                else if (dn) d = {20'h0, run_iter, run_root};
                else begin d = 0; known = 0; end
            end
        endcase
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        bit ea, ei;
        ea = (cyc_n == exp_ack_cycle);
        ei = run_valid && (cyc_n == run_done);
        check("ack", 32'(ack), 32'(ea));
        if (ea) begin
            if (exp_known) check("rdata", dat_o, exp_dat);
        end else begin
            check("rdata_idle", dat_o, 32'h0);
        end
        check("irq", 32'(irq), 32'(ei));
    end

    // ---------------- bus driver ----------------
    task automatic bus(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       input int hold, input bit expect_hit, output logic [31:0] rd);
        int c;
        @(posedge clock); #1;
        cyc = 1; stb = 1; we = w; adr = a; sel = s; dat_i = d;
        c = cyc_n;
        if (expect_hit) begin
            if (!w) model_read(a[3:2], c, exp_dat, exp_known);
            else begin exp_dat = 0; exp_known = 1; end
            exp_ack_cycle = c + 1;
        end
        @(posedge clock); #1;
        if (expect_hit && w) model_write(a[3:2], s, d, c + 1);
        @(negedge clock);
        rd = dat_o;
        repeat (hold - 1) begin @(posedge clock); #1; end
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        bus(1, BASE + 32'(r) * 4, s, d, 2, 1, dummy);
    endtask

    task automatic rd_reg(input logic [1:0] r, output logic [31:0] v);
        bus(0, BASE + 32'(r) * 4, 4'hF, 32'h0, 2, 1, v);
    endtask

    task automatic wait_done();
        int lim = 0;
        while (run_valid && cyc_n <= run_done && lim < 200) begin
            @(posedge clock); #1; lim++;
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1;
        m_lo = 0; m_hi = 0; m_n = 0; run_valid = 0; exp_ack_cycle = -10;
        repeat (2) @(posedge clock);
        #1 reset = 0;
    endtask

    task automatic run(input logic [7:0] lo, input logic [7:0] hi, input logic [15:0] n);
        wr(2'd0, {16'h0, hi, lo}, 4'hF);
        wr(2'd1, {16'h0, n}, 4'hF);
        wr(2'd2, 32'h1, 4'h1);
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int i0, mode;
        logic [7:0] lo, hi;
        logic [15:0] n;

        // pin the model against hand-worked values
        check("model_steps_0_255_100", 32'(bisect_steps(0, 255, 100)), 32'd8);
        check("model_isqrt_65024", 32'(isqrt(65024)), 32'd254);

        repeat (3) @(posedge clock);
        #1 reset = 0;

        // reset state
        for (int r = 0; r < 4; r++) begin
            rd_reg(2'(r), v);
            check("reset_reg", v, 32'h0);
        end

        // basic root of 100
        i0 = irq_cnt;
        run(8'd0, 8'd255, 16'd100);
        repeat (2) @(posedge clock);
        check("irq_pulses_100", 32'(irq_cnt - i0), 32'd1);
        rd_reg(2'd2, v); check("status_100", v, 32'h2);
        rd_reg(2'd3, v); check("result_100", v, 32'h0000_080A);

        run(8'd0, 8'd1, 16'd0);
        rd_reg(2'd3, v); check("result_0", v, 32'h0);
        rd_reg(2'd2, v); check("status_0", v, 32'h2);
        run(8'd20, 8'd10, 16'd50);
        rd_reg(2'd2, v); check("status_lo_gt_hi", v, 32'h6);
        rd_reg(2'd3, v); check("result_lo_gt_hi", v, 32'h0);
        run(8'd0, 8'd255, 16'd65535);
        rd_reg(2'd2, v); check("status_hi_sq_le_n", v, 32'h6);
        run(8'd0, 8'd255, 16'd65024);
        rd_reg(2'd3, v); check("root_65024", {24'h0, v[7:0]}, 32'd254);

        // byte enables, held strobe, out-of-window address
        wr(2'd0, 32'h0000_FF05, 4'hF);
        wr(2'd0, 32'h0000_4000, 4'b0010);
        rd_reg(2'd0, v); check("oper_sel1", v, 32'h0000_4005);
        bus(0, BASE + 32'h4, 4'hF, 32'h0, 3, 1, v);
        bus(1, BASE + 32'h10, 4'hF, 32'h0000_1234, 2, 0, v);
        bus(0, BASE + 32'h10, 4'hF, 32'h0, 2, 0, v);
        rd_reg(2'd0, v); check("oper_after_oob", v, 32'h0000_4005);

        // writes and restart while busy do not disturb the running search
        wr(2'd0, 32'h0000_FF00, 4'hF);
        wr(2'd1, 32'd100, 4'hF);
        wr(2'd2, 32'h1, 4'h1);
        wr(2'd1, 32'd9, 4'hF);
        wr(2'd2, 32'h1, 4'h1);
        rd_reg(2'd2, v); check("busy_mid_run", {31'h0, v[0]}, 32'h1);
        wait_done();
        rd_reg(2'd3, v); check("result_after_busy_writes", v, 32'h0000_080A);
        rd_reg(2'd1, v); check("target_visible", v, 32'd9);

        // reset during ITER aborts without an interrupt
        wr(2'd1, 32'd100, 4'hF);
        wr(2'd2, 32'h1, 4'h1);
        repeat (3) @(posedge clock);
        i0 = irq_cnt;
        do_reset();
        repeat (15) @(posedge clock);
        check("irq_after_reset", 32'(irq_cnt - i0), 32'd0);
        rd_reg(2'd2, v); check("status_after_reset", v, 32'h0);
        for (int r = 0; r < 4; r++) begin
            rd_reg(2'(r), v);
            check("reg_after_reset", v, 32'h0);
        end
        run(8'd0, 8'd255, 16'd100);
        rd_reg(2'd3, v); check("result_fresh", v, 32'h0000_080A);

        // randomized runs
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(3, 0);
            if (mode != 0) begin
                lo = 8'($urandom_range(200, 0));
                hi = 8'($urandom_range(255, 32'(lo) + 1));
                n  = 16'($urandom_range(32'(hi) * 32'(hi) - 1, 32'(lo) * 32'(lo)));
            end else begin
                lo = 8'($urandom); hi = 8'($urandom); n = 16'($urandom);
            end
            wr(2'd0, {16'h0, hi, lo}, 4'hF);
            wr(2'd1, {16'h0, n}, 4'hF);
            if ($urandom_range(3, 0) == 0) wr(2'($urandom), $urandom, 4'($urandom));
            wr(2'd2, 32'h1, 4'h1);
            if ($urandom_range(1, 0) == 1) begin
                wr(2'($urandom), $urandom, 4'($urandom));
                rd_reg(2'd2, v);
            end
            wait_done();
            rd_reg(2'd2, v);
            rd_reg(2'd3, v);
            rd_reg(2'($urandom), v);
        end

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
